// File: rtl/otbn_pq_pkg.sv
// rtl/otbn_pq_pkg.sv - shared PQ constants, NTT mode enum and command payload type
//
// Purpose: op codes issued by the NTT sequencer, the transform direction enum
// and the packed butterfly command bundle handed to the PQ issue stage.
// Ports: none (package).
package otbn_pq_pkg;

  localparam int NttMaxLogN = 8;
  localparam int NttWdrAw   = 5;

  localparam logic [7:0] PQ_OP_CT_BF = 8'h30;
  localparam logic [7:0] PQ_OP_GS_BF = 8'h92;
  localparam logic [7:0] PQ_OP_SCALE = 8'h09;

  typedef enum logic {
    NttCt = 1'b0,
    NttGs = 1'b1
  } ntt_mode_e;

  typedef struct packed {
    logic [7:0]            op;
    logic [NttWdrAw-1:0]   wdr_a;
    logic [2:0]            wsel_a;
    logic [NttWdrAw-1:0]   wdr_b;
    logic [2:0]            wsel_b;
    logic [NttMaxLogN-1:0] tw_idx;
    logic                  last;
  } ntt_cmd_t;

endpackage

// File: rtl/otbn_pq_ntt_addr_gen.sv
// rtl/otbn_pq_ntt_addr_gen.sv - coefficient index to (WDR, word select) mapper
//
// Purpose: coefficients are packed 8 per 256-bit WDR starting at base_i, so
// the low 3 index bits pick the 32-bit word and the rest offset the WDR.
// Ports:
//   coef_i  in   coefficient index (< N)
//   base_i  in   WDR holding coefficient 0
//   wdr_o   out  WDR index holding the coefficient
//   wsel_o  out  32-bit word select inside that WDR
module otbn_pq_ntt_addr_gen #(
  parameter int MAX_LOG_N = 8,
  parameter int WDR_AW    = 5
) (
  input  logic [MAX_LOG_N-1:0] coef_i,
  input  logic [WDR_AW-1:0]    base_i,
  output logic [WDR_AW-1:0]    wdr_o,
  output logic [2:0]           wsel_o
);

  logic [MAX_LOG_N-1:0] word_idx;

  assign word_idx = coef_i >> 3;
  assign wdr_o    = base_i + WDR_AW'(word_idx);
  assign wsel_o   = coef_i[2:0];

endmodule

// File: rtl/otbn_pq_ntt_seq.sv
// rtl/otbn_pq_ntt_seq.sv - forward CT / inverse GS NTT butterfly command sequencer
//
// Purpose: walks every butterfly of an N = 2^log_n point NTT and emits one
// registered command per valid/ready handshake. Optional build macro
// OTBN_PQ_NTT_SCALE_EN appends an N-command SCALE pass to inverse transforms.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   start_i, mode_i, log_n_i,       launch request and transform config
//   base_wdr_i, abort_i             (config sampled only when idle), abort
//   busy_o, done_o, err_o           status: running, completion pulse, bad start
//   cmd_valid_o, cmd_ready_i        command handshake
//   cmd_op_o, cmd_wdr_a_o,          butterfly payload (op, operand locations,
//   cmd_wsel_a_o, cmd_wdr_b_o,      twiddle index, final-command marker)
//   cmd_wsel_b_o, cmd_tw_idx_o,
//   cmd_last_o
module otbn_pq_ntt_seq
  import otbn_pq_pkg::*;
#(
  parameter int MAX_LOG_N = NttMaxLogN,
  parameter int WDR_AW    = NttWdrAw
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [3:0]           log_n_i,
  input  logic [WDR_AW-1:0]    base_wdr_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [7:0]           cmd_op_o,
  output logic [WDR_AW-1:0]    cmd_wdr_a_o,
  output logic [2:0]           cmd_wsel_a_o,
  output logic [WDR_AW-1:0]    cmd_wdr_b_o,
  output logic [2:0]           cmd_wsel_b_o,
  output logic [MAX_LOG_N-1:0] cmd_tw_idx_o,
  output logic                 cmd_last_o
);

  localparam int CW = MAX_LOG_N + 1;
  localparam int EW = CW + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t One = cnt_t'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
`ifdef OTBN_PQ_NTT_SCALE_EN
  localparam logic [1:0] StScale = 2'd3;
  localparam bit ScaleEn = 1'b1;
`else
  localparam bit ScaleEn = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  ntt_mode_e         mode_q, mode_d;
  cnt_t              n_q, n_d, len_q, len_d, grp_q, grp_d, off_q, off_d, k_q, k_d;
  logic [WDR_AW-1:0] base_q, base_d;
  ntt_cmd_t          cmd_q, cmd_d, cmd_new;
  logic              valid_q, valid_d, err_q, err_d;

  // Start configuration check.
  cnt_t        n_start;
  logic [EW-1:0] wdr_end;
  logic        cfg_ok;
  assign n_start = One << log_n_i;
  assign wdr_end = EW'(base_wdr_i) + EW'(n_start >> 3);
  assign cfg_ok  = (log_n_i >= 4'd3) && (log_n_i <= 4'(MAX_LOG_N)) &&
                   (wdr_end <= EW'(1 << WDR_AW));

  logic in_scale;
`ifdef OTBN_PQ_NTT_SCALE_EN
  assign in_scale = (state_q == StScale);
`else
  assign in_scale = 1'b0;
`endif

  // Counters for the command after the one currently presented.
  // SCALE reuses off as the coefficient counter with len = grp = 0 so both
  // operand addresses collapse onto the same coefficient.
  cnt_t adv_len, adv_grp, adv_off, adv_k, grp_next, k_step;
  logic adv_scale;
  always_comb begin
    adv_len   = len_q;
    adv_grp   = grp_q;
    adv_off   = off_q + One;
    adv_k     = k_q;
    adv_scale = 1'b0;
    grp_next  = grp_q + (len_q << 1);
    k_step    = (mode_q == NttGs) ? k_q - One : k_q + One;
    if (in_scale) begin
      adv_scale = 1'b1;
    end else if (adv_off >= len_q) begin
      adv_off = '0;
      adv_k   = k_step;
      if (grp_next < n_q) begin
        adv_grp = grp_next;
      end else begin
        adv_grp = '0;
        adv_len = (mode_q == NttGs) ? (len_q << 1) : (len_q >> 1);
        if (ScaleEn && mode_q == NttGs && len_q == (n_q >> 1)) begin
          adv_scale = 1'b1;
          adv_len   = '0;
          adv_k     = '0;
        end
      end
    end
  end

  // Counters that the next registered command is built from: initial values
  // when launching from IDLE, otherwise the advanced values.
  ntt_mode_e         sel_mode;
  cnt_t              sel_n, sel_len, sel_grp, sel_off, sel_k;
  logic [WDR_AW-1:0] sel_base;
  logic              sel_scale;
  always_comb begin
    if (state_q == StIdle) begin
      sel_mode  = ntt_mode_e'(mode_i);
      sel_n     = n_start;
      sel_base  = base_wdr_i;
      sel_len   = mode_i ? One : (n_start >> 1);
      sel_k     = mode_i ? (n_start - One) : One;
      sel_grp   = '0;
      sel_off   = '0;
      sel_scale = 1'b0;
    end else begin
      sel_mode  = mode_q;
      sel_n     = n_q;
      sel_base  = base_q;
      sel_len   = adv_len;
      sel_k     = adv_k;
      sel_grp   = adv_grp;
      sel_off   = adv_off;
      sel_scale = adv_scale;
    end
  end

  // Final butterfly: last pair of the last group of the last layer.
  logic bf_last, sel_last;
  assign bf_last  = (sel_off + One == sel_len) && (sel_grp + (sel_len << 1) == sel_n) &&
                    ((sel_mode == NttGs) ? (sel_len == (sel_n >> 1)) : (sel_len == One));
  assign sel_last = sel_scale ? (sel_off == sel_n - One)
                              : (bf_last && !(ScaleEn && sel_mode == NttGs));

  logic [MAX_LOG_N-1:0] coef_a, coef_b;
  logic [WDR_AW-1:0]    wdr_a, wdr_b;
  logic [2:0]           wsel_a, wsel_b;
  assign coef_a = MAX_LOG_N'(sel_grp + sel_off);
  assign coef_b = MAX_LOG_N'(sel_grp + sel_off + sel_len);

  otbn_pq_ntt_addr_gen #(.MAX_LOG_N(MAX_LOG_N), .WDR_AW(WDR_AW)) u_addr_a (
    .coef_i(coef_a), .base_i(sel_base), .wdr_o(wdr_a), .wsel_o(wsel_a)
  );
  otbn_pq_ntt_addr_gen #(.MAX_LOG_N(MAX_LOG_N), .WDR_AW(WDR_AW)) u_addr_b (
    .coef_i(coef_b), .base_i(sel_base), .wdr_o(wdr_b), .wsel_o(wsel_b)
  );

  always_comb begin
    cmd_new.op     = sel_scale ? PQ_OP_SCALE :
                     ((sel_mode == NttGs) ? PQ_OP_GS_BF : PQ_OP_CT_BF);
    cmd_new.wdr_a  = wdr_a;
    cmd_new.wsel_a = wsel_a;
    cmd_new.wdr_b  = wdr_b;
    cmd_new.wsel_b = wsel_b;
    cmd_new.tw_idx = MAX_LOG_N'(sel_k);
    cmd_new.last   = sel_last;
  end

  logic load;
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    n_d     = n_q;
    base_d  = base_q;
    len_d   = len_q;
    grp_d   = grp_q;
    off_d   = off_q;
    k_d     = k_q;
    cmd_d   = cmd_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    load    = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
      valid_d = 1'b0;
      cmd_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (cfg_ok) load = 1'b1;
            else        err_d = 1'b1;
          end
        end
        StDone: state_d = StIdle;
        default: begin
          if (valid_q && cmd_ready_i) begin
            if (cmd_q.last) begin
              state_d = StDone;
              valid_d = 1'b0;
              cmd_d   = '0;
            end else begin
              load = 1'b1;
            end
          end
        end
      endcase
    end
    if (load) begin
      state_d = StRun;
`ifdef OTBN_PQ_NTT_SCALE_EN
      if (sel_scale) state_d = StScale;
`endif
      mode_d  = sel_mode;
      n_d     = sel_n;
      base_d  = sel_base;
      len_d   = sel_len;
      grp_d   = sel_grp;
      off_d   = sel_off;
      k_d     = sel_k;
      valid_d = 1'b1;
      cmd_d   = cmd_new;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mode_q  <= NttCt;
      n_q     <= '0;
      base_q  <= '0;
      len_q   <= '0;
      grp_q   <= '0;
      off_q   <= '0;
      k_q     <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      base_q  <= base_d;
      len_q   <= len_d;
      grp_q   <= grp_d;
      off_q   <= off_d;
      k_q     <= k_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign err_o        = err_q;
  assign cmd_valid_o  = valid_q;
  assign cmd_op_o     = cmd_q.op;
  assign cmd_wdr_a_o  = cmd_q.wdr_a;
  assign cmd_wsel_a_o = cmd_q.wsel_a;
  assign cmd_wdr_b_o  = cmd_q.wdr_b;
  assign cmd_wsel_b_o = cmd_q.wsel_b;
  assign cmd_tw_idx_o = cmd_q.tw_idx;
  assign cmd_last_o   = cmd_q.last;

endmodule

// File: tb/tb_otbn_pq_ntt_seq.sv
// tb/tb_otbn_pq_ntt_seq.sv - scoreboard testbench for otbn_pq_ntt_seq
module tb_otbn_pq_ntt_seq;

  logic       clk = 1'b0;
  logic       rst_i, start_i, mode_i, abort_i, cmd_ready_i;
  logic [3:0] log_n_i;
  logic [4:0] base_wdr_i;
  logic       busy_o, done_o, err_o, cmd_valid_o, cmd_last_o;
  logic [7:0] cmd_op_o, cmd_tw_idx_o;
  logic [4:0] cmd_wdr_a_o, cmd_wdr_b_o;
  logic [2:0] cmd_wsel_a_o, cmd_wsel_b_o;

  otbn_pq_ntt_seq dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .log_n_i(log_n_i), .base_wdr_i(base_wdr_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_op_o(cmd_op_o),
    .cmd_wdr_a_o(cmd_wdr_a_o), .cmd_wsel_a_o(cmd_wsel_a_o),
    .cmd_wdr_b_o(cmd_wdr_b_o), .cmd_wsel_b_o(cmd_wsel_b_o),
    .cmd_tw_idx_o(cmd_tw_idx_o), .cmd_last_o(cmd_last_o)
  );

  always #5 clk = ~clk;

  wire [32:0] cur = {cmd_op_o, cmd_wdr_a_o, cmd_wsel_a_o, cmd_wdr_b_o, cmd_wsel_b_o,
                     cmd_tw_idx_o, cmd_last_o};
  wire [36:0] all_outs = {busy_o, done_o, err_o, cmd_valid_o, cur};

  logic [32:0] exp_q[$];
  int n_vec = 0, n_fail = 0;
  int hs_cnt = 0, done_cnt = 0;
  bit rand_rdy = 1'b0, rdy_fix = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [32:0] mk(input logic [7:0] op, input int a, input int b,
                                     input int tw, input int base);
    logic [4:0] wa, wb;
    wa = 5'(base + (a >> 3));
    wb = 5'(base + (b >> 3));
    return {op, wa, 3'(a), wb, 3'(b), 8'(tw), 1'b0};
  endfunction

  // Reference sequence built straight from the transform's loop structure.
  task automatic gen(input int mode, input int log_n, input int base);
    int n;
    int k;
    logic [32:0] q[$];
    logic [32:0] fin;
    n = 1 << log_n;
    if (mode == 0) begin
      k = 0;
      for (int len = n / 2; len >= 1; len = len / 2)
        for (int st = 0; st < n; st += 2 * len) begin
          k++;
          for (int j = st; j < st + len; j++) q.push_back(mk(8'h30, j, j + len, k, base));
        end
    end else begin
      k = n;
      for (int len = 1; len <= n / 2; len = len * 2)
        for (int st = 0; st < n; st += 2 * len) begin
          k--;
          for (int j = st; j < st + len; j++) q.push_back(mk(8'h92, j, j + len, k, base));
        end
`ifdef OTBN_PQ_NTT_SCALE_EN
      for (int c = 0; c < n; c++) q.push_back(mk(8'h09, c, c, 0, base));
`endif
    end
    fin = q.pop_back();
    fin[0] = 1'b1;
    q.push_back(fin);
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  always @(posedge clk) begin
    #1;
    cmd_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  // Monitor: pops one expected command per handshake, checks stall stability.
  logic [32:0] prev_cmd;
  bit stall_q = 1'b0;
  always @(negedge clk) begin
    if (rst_i) begin
      stall_q = 1'b0;
    end else begin
      if (done_o) done_cnt++;
      if (stall_q) chk("stall_stable", {cmd_valid_o, cur}, {1'b1, prev_cmd});
      if (cmd_valid_o && cmd_ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_cmd: got %h expected none", cur);
        end else begin
          chk("cmd", cur, exp_q.pop_front());
          hs_cnt++;
        end
      end
      stall_q  = cmd_valid_o && !cmd_ready_i;
      prev_cmd = cur;
    end
  end

  task automatic launch(input int mode, input int ln, input int base);
    @(posedge clk); #1;
    start_i = mode[0] | 1'b0; start_i = 1'b1;
    mode_i = mode[0]; log_n_i = 4'(ln); base_wdr_i = 5'(base);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_xform(input int mode, input int ln, input int base, input bit poke,
                           output int cyc, output int tot);
    gen(mode, ln, base);
    tot = exp_q.size();
    launch(mode, ln, base);
    cyc = 1;
    while (!done_o && cyc < 20000) begin
      if (poke && exp_q.size() > 3 && $urandom_range(0, 7) == 0) begin
        start_i = 1'b1; mode_i = ~mode_i;
        log_n_i = 4'($urandom_range(3, 8)); base_wdr_i = '0;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      cyc++;
    end
    chk("done_seen", done_o, 1);
    @(posedge clk); #1;
    chk("after_done", {done_o, busy_o, cmd_valid_o}, 0);
    chk("queue_drained", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic illegal(input int ln, input int base);
    logic [2:0] acc;
    acc = '0;
    launch(0, ln, base);
    chk("illegal_err", {err_o, busy_o, cmd_valid_o}, 3'b100);
    repeat (4) begin
      @(posedge clk); #1;
      acc |= {err_o, busy_o, cmd_valid_o};
    end
    chk("illegal_quiet", acc, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, tot, md, ln, bs, h0, d0, t;
    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; abort_i = 1'b0;
    log_n_i = '0; base_wdr_i = '0; cmd_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("reset_outputs", all_outs, 0);

    run_xform(0, 3, 4, 0, cyc, tot);
    chk("ct3_count", 64'(tot), 12);
    chk("ct3_cycles", 64'(cyc), 64'(tot + 1));
    run_xform(1, 3, 0, 0, cyc, tot);
    chk("gs3_cycles", 64'(cyc), 64'(tot + 1));
    run_xform(1, 4, 30, 0, cyc, tot);
    chk("gs4_top_cycles", 64'(cyc), 64'(tot + 1));

    rand_rdy = 1'b1;
    run_xform(0, 3, 4, 0, cyc, tot);
    for (int i = 0; i < 8; i++) begin
      md = $urandom_range(0, 1);
      ln = $urandom_range(3, 8);
      bs = $urandom_range(0, 32 - (1 << ln) / 8);
      run_xform(md, ln, bs, 1, cyc, tot);
    end
    rand_rdy = 1'b0; rdy_fix = 1'b1;

    illegal(2, 0);
    illegal(8, 1);
    illegal(9, 0);
    illegal(4, 31);

    // Abort in the second CT layer of N=16 (first layer is 8 commands).
    gen(0, 4, 0);
    h0 = hs_cnt; d0 = done_cnt; t = 0;
    launch(0, 4, 0);
    while (hs_cnt - h0 < 10 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_idle", {cmd_valid_o, busy_o}, 0);
    chk("abort_hs", 64'(hs_cnt - h0), 11);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1 chk("abort_no_done", 64'(done_cnt - d0), 0);
    run_xform(0, 4, 0, 0, cyc, tot);
    chk("post_abort_cycles", 64'(cyc), 64'(tot + 1));

    // Reset while a command is stalled.
    rdy_fix = 1'b0;
    gen(0, 5, 0);
    launch(0, 5, 0);
    repeat (2) @(posedge clk);
    #1 chk("stalled_valid", cmd_valid_o, 1);
    rst_i = 1'b1;
    #1 chk("reset_mid_run", all_outs, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_i = 1'b0; rdy_fix = 1'b1;
    run_xform(1, 5, 2, 1, cyc, tot);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/otbn_pq_ntt_seq.md
Name: otbn_pq_ntt_seq

Overview:
- Sequencer that walks a full forward NTT (Cooley-Tukey) or inverse NTT (Gentleman-Sande) over N = 2^log_n 32-bit coefficients.
- Coefficients are packed 8 per 256-bit WDR, in consecutive WDRs starting at a base index.
- Emits one butterfly command per handshake to the PQ issue stage: ALU op code, WDR indices, word selects and twiddle index.
- Sits between the PQ instruction decoder (start/config) and the PQ ALU operand fetch/writeback path.

Parameters:
- MAX_LOG_N, 8, largest supported log2 of coefficient count (N <= 256).
- WDR_AW, 5, WDR index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  launch transform; sampled only when idle
- mode_i  in  1  0 = forward CT NTT, 1 = inverse GS NTT
- log_n_i  in  4  log2 N; legal range 3..MAX_LOG_N
- base_wdr_i  in  WDR_AW  first WDR holding coefficient 0
- abort_i  in  1  synchronous abort; wins over everything except reset
- busy_o  out  1  transform in progress
- done_o  out  1  one-cycle pulse after final handshake
- err_o  out  1  one-cycle pulse on illegal start
- cmd_valid_o  out  1  command payload valid
- cmd_ready_i  in  1  downstream accepts command
- cmd_op_o  out  8  ALU op vector
- cmd_wdr_a_o  out  WDR_AW  WDR of coefficient j
- cmd_wsel_a_o  out  3  word select of j
- cmd_wdr_b_o  out  WDR_AW  WDR of coefficient j+len
- cmd_wsel_b_o  out  3  word select of j+len
- cmd_tw_idx_o  out  MAX_LOG_N  twiddle table index
- cmd_last_o  out  1  marks final command

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- FSM states:
  - IDLE -> RUN on start_i with legal config.
  - RUN -> DONE on handshake (valid & ready) of the command with cmd_last_o=1.
  - DONE -> IDLE after 1 cycle; done_o=1 during DONE.
- Illegal start (log_n_i outside 3..MAX_LOG_N, or base_wdr_i + N/8 > 32): err_o pulses for 1 cycle and the FSM stays in IDLE.
- start_i is ignored while busy_o=1.
- busy_o=1 in RUN and DONE.
- Latency: first cmd_valid_o appears in the cycle after start_i is accepted. Payload is registered. A new command can issue every cycle while cmd_ready_i=1.
- Handshake: once cmd_valid_o is raised, the payload stays stable until cmd_ready_i. Counters advance only on handshake. cmd_valid_o never drops without a handshake, except on abort or reset.
- Coefficient c maps to: wdr = base_wdr_i + c[log_n-1:3], wsel = c[2:0].
- CT order (mode 0):
  - len = N/2 down to 1, halving each layer.
  - For start = 0, 2len, ... < N: k increments before each group, starting from k = 0, so the first group uses k = 1.
  - For j = start .. start+len-1: emit butterfly (j, j+len) with tw_idx = k.
  - op = 8'h30: twiddle multiply, rs0 = a + b*w, rs1 = a - b*w.
- GS order (mode 1):
  - len = 1 up to N/2, doubling each layer.
  - k starts at N and decrements before each group, so the first group uses k = N-1.
  - Butterfly order within a group is the same as CT.
  - op = 8'h92: rs0 = a + b, rs1 = (a - b)*w.
- Total commands: (N/2)*log_n. cmd_last_o is set only on the final one.
- Loop counters (j, len, k) use MAX_LOG_N+1 bits. Wrap-around is never observed because layer termination is compared against N.
- abort_i in RUN:
  - Next cycle cmd_valid_o=0 and the FSM returns to IDLE.
  - No done_o pulse.
  - A handshake in the same cycle as abort still counts downstream, but is not followed by further commands.
- Reset mid-operation: immediate return to IDLE and the reset values above.

Optional Feature:
- Macro: OTBN_PQ_NTT_SCALE_EN.
- When defined and mode 1: after the last GS butterfly, a SCALE phase emits N single-coefficient commands, c = 0..N-1.
  - op = 8'h09: rd = coefficient * scale (the n^-1 Montgomery constant).
  - wdr_a = wdr_b = wdr(c), wsel_a = wsel_b = wsel(c), tw_idx = 0.
  - cmd_last_o moves to command c = N-1.
- Without the macro: no SCALE state. Mode 1 ends at the last butterfly.

Decomposition:
- Add to otbn_pq_pkg:
  - op constants PQ_OP_CT_BF=8'h30, PQ_OP_GS_BF=8'h92, PQ_OP_SCALE=8'h09;
  - typedef ntt_mode_e {NttCt, NttGs};
  - typedef ntt_cmd_t bundling the cmd payload fields.
- One sub-module is natural: otbn_pq_ntt_addr_gen, a combinational coefficient-index to (wdr, wsel) mapper, instantiated twice.

Test Plan:
- CT, log_n=3, base=4, ready tied 1:
  - 12 commands on consecutive cycles.
  - First command: (wdr 4/wsel 0, wdr 4/wsel 4, tw 1), op 8'h30.
  - Layer-2 first command: (0,2) with tw 2.
  - Last command: (6,7) with tw 7, cmd_last_o=1.
  - done_o pulses 1 cycle after the last command.
- GS, log_n=3, base=0:
  - First command: (0,1) with tw 7.
  - Final layer: (0,4)..(3,7), all with tw 1, op 8'h92.
  - With OTBN_PQ_NTT_SCALE_EN: 8 further op 8'h09 commands follow.
- Backpressure: random cmd_ready_i -> payload stable while stalled, no command dropped or duplicated, total count 12.
- Illegal start with log_n=2, or with log_n=8 and base=1 -> err_o 1-cycle pulse, busy_o stays 0, no cmd_valid_o.
- Abort mid-layer 2 -> cmd_valid_o=0 next cycle, no done_o; a subsequent start runs a full correct sequence.
- Assert rst_i during RUN with valid pending -> all outputs 0 immediately; start_i while busy has no effect.
